sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3, cycles per 16-bit SRAM access phase; legal range 2..15.
REQ-002 SHALL have parameter DATA_MEM_BASE, default 1024, byte address of data memory word 0.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have the following remaining ports:
- rd_en  in  1  load request from the EXE/MEM register.
- wr_en  in  1  store request from the EXE/MEM register.
- address  in  32  byte address (ALU result).
- wdata  in  32  store value.
- rdata  out  32  load result, valid when ready=1 in DONE.
- ready  out  1  0 = freeze the pipeline.
- sram_addr  out  18  halfword address.
- sram_dq_out  out  16  write data to the SRAM.
- sram_dq_in  in  16  read data from the SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out.
- sram_we_n  out  1  active-low write strobe.

Function
REQ-005 SHALL implement states IDLE, LOW, HIGH and DONE.
REQ-006 IDLE: ready = ~(rd_en | wr_en), combinational; on a request, latch address/wdata/op and go to LOW next cycle.
REQ-007 Operation SHALL be latched: deasserting rd_en/wr_en or changing address/wdata mid-operation has no effect until IDLE.
REQ-008 rd_en=1 and wr_en=1 together SHALL be treated as a write.
REQ-009 Word index SHALL be (address - DATA_MEM_BASE) >> 2, 32-bit wrap-around subtraction, low 17 bits kept; address[1:0] is ignored.
REQ-010 sram_addr SHALL be {word_index, 1'b0} in LOW and {word_index, 1'b1} in HIGH; it holds its last value in IDLE/DONE.
REQ-011 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles, counted by a phase counter that resets to 0 on each phase entry.
REQ-012 Write, LOW phase: sram_dq_out=wdata[15:0] and sram_dq_oe=1 for the whole phase; sram_we_n=0 for all but the last cycle of the phase.
REQ-013 Write, HIGH phase: as REQ-012, using wdata[31:16].
REQ-014 Read: sram_dq_oe=0 and sram_we_n=1; sram_dq_in SHALL be sampled on the last cycle of LOW into rdata[15:0] and of HIGH into rdata[31:16].
REQ-015 ready SHALL be 0 in LOW and HIGH and 1 in DONE; DONE lasts one cycle and then returns to IDLE.
REQ-016 Latency SHALL be 2*WAIT_CYCLES+1 cycles from the request-accept cycle to the DONE cycle.
REQ-017 rdata SHALL hold its value until the next read completes; writes leave rdata unchanged.
REQ-018 A request present in the cycle after DONE SHALL be accepted as a new operation, allowing back-to-back accesses.

Reset
REQ-019 On rst=1 at a clk edge, the following SHALL apply:
- state=IDLE, phase counter=0.
- rdata=0, sram_addr=0, sram_dq_out=0.
- sram_dq_oe=0, sram_we_n=1.
REQ-020 Reset mid-operation SHALL abort the operation; no further SRAM strobes are driven and the request is not retried.

Structure
REQ-021 Shared package SHALL hold the state enum, the WAIT_CYCLES default and DATA_MEM_BASE.
REQ-022 No sub-module; single FSM plus phase counter and datapath registers.

Verification (WAIT_CYCLES=3, SRAM behavioural model)
REQ-023 Store 0xDEADBEEF @1024 -> model halfword 0=0xBEEF, halfword 1=0xDEAD; ready=0 for 7 cycles, then 1 for one cycle.
REQ-024 Load @1024 after REQ-023 -> rdata=0xDEADBEEF in DONE; store @1030 -> sram_addr 2/3 (address[1:0] ignored).
REQ-025 Two back-to-back loads @1024 and @1028 -> two DONE cycles 8 cycles apart; no idle cycle between operations.
REQ-026 rd_en=wr_en=1 @1032, wdata=0x12345678 -> write performed; rdata unchanged.
REQ-027 rst=1 in the second HIGH cycle of a store -> next cycle IDLE, sram_we_n=1, sram_dq_oe=0, ready=~(rd_en|wr_en).
REQ-028 Drop rd_en one cycle after accept -> operation completes; ready=1 at cycle 7.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the 32-bit-over-16-bit SRAM access controller.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          WAIT_CYCLES_DEFAULT   = 3;
    localparam logic [31:0] DATA_MEM_BASE_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM phases (low half, then high half)
// and freezes the pipeline via ready until the access completes.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          WAIT_CYCLES   = WAIT_CYCLES_DEFAULT,
    parameter logic [31:0] DATA_MEM_BASE = DATA_MEM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        is_wr;
    logic [16:0] idx_q;
    logic [15:0] wdata_hi;
    logic        req;
    logic [16:0] idx;

    assign req   = rd_en | wr_en;
    // Wrap-around subtraction; only the 17-bit word index survives the truncation.
    assign idx   = 17'((address - DATA_MEM_BASE) >> 2);
    assign ready = (state == IDLE) ? ~req : (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_wr       <= 1'b0;
            idx_q       <= '0;
            wdata_hi    <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        is_wr       <= wr_en;
                        idx_q       <= idx;
                        wdata_hi    <= wdata[31:16];
                        sram_addr   <= {idx, 1'b0};
                        sram_dq_out <= wdata[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                        cnt         <= '0;
                        state       <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == LAST) begin
                        if (!is_wr) rdata[15:0] <= sram_dq_in;
                        sram_addr   <= {idx_q, 1'b1};
                        sram_dq_out <= wdata_hi;
                        sram_we_n   <= ~is_wr;
                        cnt         <= '0;
                        state       <= HIGH;
                    end else begin
                        cnt       <= cnt + 4'd1;
                        // Strobe released one cycle early so data is held past the rising we_n.
                        sram_we_n <= ~is_wr | ((cnt + 4'd1) == LAST);
                    end
                end
                HIGH: begin
                    if (cnt == LAST) begin
                        if (!is_wr) rdata[31:16] <= sram_dq_in;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end else begin
                        cnt       <= cnt + 4'd1;
                        sram_we_n <= ~is_wr | ((cnt + 4'd1) == LAST);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
